// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: receive-FSM state encoding,
// the scancode values the prefix interpreter reacts to, and a helper that
// recognises keyboard status/response bytes that never map to a key.
// No ports (package).
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] CODE_E0     = 8'hE0;
    localparam logic [7:0] CODE_F0     = 8'hF0;
    localparam logic [7:0] CODE_E1     = 8'hE1;
    localparam logic [7:0] CODE_AA     = 8'hAA;
    localparam logic [7:0] CODE_FA     = 8'hFA;
    localparam logic [7:0] CODE_EE     = 8'hEE;
    localparam logic [7:0] CODE_FE     = 8'hFE;
    localparam logic [7:0] CODE_FC     = 8'hFC;
    localparam logic [7:0] CODE_00     = 8'h00;
    localparam logic [7:0] CODE_FF     = 8'hFF;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    // Bytes still to discard after the E1 that opens the pause sequence.
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    function automatic logic is_ctrl_code(input logic [7:0] code);
        return (code == CODE_AA) || (code == CODE_FA) || (code == CODE_EE) ||
               (code == CODE_FE) || (code == CODE_FC) || (code == CODE_00) ||
               (code == CODE_FF);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bus between a PS/2 line source and the key decoder.
//   ps2_clk, ps2_data          : raw PS/2 lines (source -> decoder)
//   key_strobe/pressed/extended: decoded key event (decoder -> consumer)
//   key_code[7:0]              : scancode of the last event
//   parity_err, frame_err      : one-cycle frame rejection pulses
// master = line source / event consumer, slave = decoder.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  key_strobe, key_pressed, key_extended, key_code,
               parity_err, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key_strobe, key_pressed, key_extended, key_code,
               parity_err, frame_err
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the raw lines, glitch-filters the clock,
// samples data on each filtered falling edge and assembles 11-bit frames.
//   clk, reset           : system clock, synchronous active-high reset
//   ps2_clk, ps2_data    : raw asynchronous PS/2 lines
//   rx_byte[7:0]         : last assembled data byte
//   byte_valid           : one-cycle pulse, frame accepted
//   parity_err           : one-cycle pulse, bad parity or stop bit
//   frame_err            : one-cycle pulse, inter-edge timeout inside a frame
//
// state      | meaning
// RX_IDLE    | waiting for a start bit (data 0 on a falling edge)
// RX_DATA    | shifting in 8 data bits, LSB first
// RX_PARITY  | capturing the parity bit
// RX_STOP    | checking stop bit and odd parity
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 21477
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = RX_IDLE;
    localparam logic [1:0] ST_DATA   = RX_DATA;
    localparam logic [1:0] ST_PARITY = RX_PARITY;
    localparam logic [1:0] ST_STOP   = RX_STOP;

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt_sr, filt_next;
    logic                  filt_clk, filt_prev, fall;
    logic [1:0]            state;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_bit;
    logic [TMO_W-1:0]      tmo;

    // Filter decisions use the post-shift value so the filtered clock moves
    // in the same cycle the register becomes uniform.
    assign filt_next = {filt_sr[FILTER_LEN-2:0], clk_s2};
    assign fall      = filt_prev & ~filt_clk;
    assign rx_byte   = shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_sr   <= '1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data;
            dat_s2    <= dat_s1;
            filt_sr   <= filt_next;
            filt_prev <= filt_clk;
            if (filt_next == '0) begin
                filt_clk <= 1'b0;
            end else if (filt_next == '1) begin
                filt_clk <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            tmo        <= '0;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            // A falling edge takes priority over a coincident timeout.
            if (fall) begin
                tmo <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!dat_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (dat_s2 && (^{shreg, par_bit})) begin
                            byte_valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state == ST_IDLE) begin
                tmo <= '0;
            end else if (tmo == TMO_LAST) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                tmo       <= '0;
            end else begin
                tmo <= tmo + TMO_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns raw PS/2 lines into one-cycle key events
// with make/break and E0-extended flags; prefixes, the pause sequence,
// status bytes and fake shifts are swallowed here.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of ps2_key_decoder_if (raw lines in,
//                key event and error pulses out)
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 21477
) (
    input logic              clk,
    input logic              reset,
    ps2_key_decoder_if.slave bus
);

    logic [7:0] rx_byte;
    logic       byte_valid, rx_parity_err, rx_frame_err;
    logic       ext_f, brk_f;
    logic [2:0] skip;
    logic       key_strobe, key_pressed, key_extended;
    logic [7:0] key_code;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .parity_err (rx_parity_err),
        .frame_err  (rx_frame_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_f        <= 1'b0;
            brk_f        <= 1'b0;
            skip         <= 3'd0;
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= 8'h00;
        end else begin
            key_strobe <= 1'b0;
            // A rejected frame may have been part of a prefixed key, so the
            // pending flags are dropped; the pause skip count survives.
            if (rx_parity_err || rx_frame_err) begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end else if (byte_valid) begin
                if (skip != 3'd0) begin
                    skip <= skip - 3'd1;
                end else if (rx_byte == CODE_E0) begin
                    ext_f <= 1'b1;
                end else if (rx_byte == CODE_F0) begin
                    brk_f <= 1'b1;
                end else if (rx_byte == CODE_E1) begin
                    skip <= PAUSE_SKIP;
                end else if (is_ctrl_code(rx_byte) ||
                             (ext_f && ((rx_byte == CODE_LSHIFT) ||
                                        (rx_byte == CODE_RSHIFT)))) begin
                    ext_f <= 1'b0;
                    brk_f <= 1'b0;
                end else begin
                    key_strobe   <= 1'b1;
                    key_code     <= rx_byte;
                    key_pressed  <= ~brk_f;
                    key_extended <= ext_f;
                    ext_f        <= 1'b0;
                    brk_f        <= 1'b0;
                end
            end
        end
    end

    assign bus.key_strobe   = key_strobe;
    assign bus.key_pressed  = key_pressed;
    assign bus.key_extended = key_extended;
    assign bus.key_code     = key_code;
    assign bus.parity_err   = rx_parity_err;
    assign bus.frame_err    = rx_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed PS/2 byte sequences followed by a
// random byte stream, checked against a byte-level reference interpreter.
module tb_ps2_key_decoder;
    localparam int FILT = 8;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .FILTER_LEN (FILT),
        .TIMEOUT    (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [9:0] exp_q[$];
    int   m_skip;
    logic m_ext, m_brk;
    int   exp_perr  = 0;
    int   exp_ferr  = 0;
    int   seen_perr = 0;
    int   seen_ferr = 0;
    logic prev_strobe = 1'b0;
    logic prev_perr   = 1'b0;
    logic prev_ferr   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference interpreter working on whole received bytes.
    task automatic model_reset();
        m_skip = 0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if ((b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF}) ||
                     (m_ext && (b == 8'h12 || b == 8'h59))) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            exp_q.push_back({m_ext, ~m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_bad_frame(input bit is_timeout);
        if (is_timeout) exp_ferr++;
        else            exp_perr++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        wait_cycles(HALF / 2);
        bus.ps2_clk = 1'b0;
        wait_cycles(HALF);
        bus.ps2_clk = 1'b1;
        wait_cycles(HALF / 2);
    endtask

    // kind: 0 good frame, 1 wrong parity bit, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input int kind);
        logic par;
        if (kind == 0) model_byte(b);
        else           model_bad_frame(1'b0);
        par = ~(^b);
        if (kind == 1) par = ~par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(kind == 2 ? 1'b0 : 1'b1);
        bus.ps2_data = 1'b1;
        wait_cycles(2 * HALF);
    endtask

    task automatic check_pending(input string tag);
        wait_cycles(20);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_perr"}, seen_perr, exp_perr);
        check_eq({tag, "_ferr"}, seen_ferr, exp_ferr);
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (!reset) begin
            if (bus.key_strobe) begin
                check_eq("strobe_width", prev_strobe, 0);
                check_eq("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("key_event", {bus.key_extended, bus.key_pressed, bus.key_code}, e);
                end
            end
            if (bus.parity_err) begin
                check_eq("perr_width", prev_perr, 0);
                seen_perr++;
            end
            if (bus.frame_err) begin
                check_eq("ferr_width", prev_ferr, 0);
                seen_ferr++;
            end
        end
        prev_strobe = bus.key_strobe;
        prev_perr   = bus.parity_err;
        prev_ferr   = bus.frame_err;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int         kind;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        wait_cycles(5);
        check_eq("rst_strobe",   bus.key_strobe, 0);
        check_eq("rst_code",     bus.key_code, 0);
        check_eq("rst_pressed",  bus.key_pressed, 0);
        check_eq("rst_extended", bus.key_extended, 0);
        check_eq("rst_perr",     bus.parity_err, 0);
        check_eq("rst_ferr",     bus.frame_err, 0);
        reset = 1'b0;
        wait_cycles(30);

        // plain make code, outputs held afterwards
        send_frame(8'h1C, 0);
        wait_cycles(100);
        check_eq("hold_code",     bus.key_code, 8'h1C);
        check_eq("hold_pressed",  bus.key_pressed, 1);
        check_eq("hold_extended", bus.key_extended, 0);
        check_pending("make");

        // extended break
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        check_pending("ext_break");

        // parity error drops the F0
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 1);
        send_frame(8'h1B, 0);
        check_eq("after_perr_pressed", bus.key_pressed, 1);
        check_pending("parity");

        // truncated frame -> timeout
        model_bad_frame(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus.ps2_data = 1'b1;
        wait_cycles(TMO + 100);
        send_frame(8'h29, 0);
        check_eq("after_tmo_code", bus.key_code, 8'h29);
        check_pending("timeout");

        // pause sequence, then a real key, then a fake shift
        send_frame(8'hE1, 0);
        send_frame(8'h14, 0);
        send_frame(8'h77, 0);
        send_frame(8'hE1, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h14, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h77, 0);
        send_frame(8'h5A, 0);
        send_frame(8'hE0, 0);
        send_frame(8'h12, 0);
        check_eq("pause_code", bus.key_code, 8'h5A);
        check_pending("pause");

        // short clock glitch while data is low must not start a frame
        bus.ps2_data = 1'b0;
        wait_cycles(HALF);
        bus.ps2_clk = 1'b0;
        wait_cycles(3);
        bus.ps2_clk = 1'b1;
        wait_cycles(HALF);
        bus.ps2_data = 1'b1;
        wait_cycles(HALF);
        send_frame(8'h1C, 0);
        check_pending("glitch");

        // reset in the middle of a frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        wait_cycles(5);
        check_eq("midrst_code",    bus.key_code, 0);
        check_eq("midrst_pressed", bus.key_pressed, 0);
        reset = 1'b0;
        model_reset();
        wait_cycles(30);
        send_frame(8'h1A, 0);
        check_pending("mid_reset");

        // random byte stream, occasionally corrupted
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       rb = 8'hE0;
                1:       rb = 8'hF0;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            kind = $urandom_range(0, 11);
            if (kind > 2) kind = 0;
            send_frame(rb, kind);
        end
        check_pending("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
